// File: rtl/dff_mem_arbiter.sv
// Round-robin arbiter and sequencer in front of a 16x8 DFF RAM with 1-cycle read latency.
// Zero-fills the RAM after reset and routes each read response back to its issuing requester.
module dff_mem_arbiter #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int RAM_BYTES      = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                last_grant_q;
  logic                owner_q;
  logic                rsp0_valid_q;
  logic                rsp1_valid_q;
  logic [DATA_W-1:0]   rsp0_rdata_q;
  logic [DATA_W-1:0]   rsp1_rdata_q;

  logic                idle_en;
  logic                grant0;
  logic                grant1;
  logic                grant_we;

  // On contention the requester that did not win last time is served.
  always_comb begin
    idle_en   = (state_q == S_IDLE) && ena;
    grant0    = idle_en && req0_valid && (!req1_valid || last_grant_q);
    grant1    = idle_en && req1_valid && (!req0_valid || !last_grant_q);
    grant_we  = grant1 ? req1_we : req0_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state_q == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
    end else if (grant0) begin
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      mem_we    = req0_we;
      mem_re    = !req0_we;
    end else if (grant1) begin
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      mem_we    = req1_we;
      mem_re    = !req1_we;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state_q == S_CLEAR);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == ADDR_W'(RAM_BYTES - 1)) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (grant0 || grant1) begin
            last_grant_q <= grant1;
            if (!grant_we) begin
              owner_q <= grant1;
              state_q <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          // RAM output is valid now; it belongs to whoever issued the read.
          if (owner_q) begin
            rsp1_valid_q <= 1'b1;
            rsp1_rdata_q <= mem_rdata;
          end else begin
            rsp0_valid_q <= 1'b1;
            rsp0_rdata_q <= mem_rdata;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// Self-checking bench for dff_mem_arbiter: behavioural RAM + per-cycle reference model
// plus directed scenarios with hand-computed expectations.
module tb_dff_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re, busy;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;
  int rsp0Count = 0;
  int rsp1Count = 0;

  dff_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_BYTES(NB), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo++;

  // The RAM macro; non-zero power-up contents so the zero-fill is observable.
  logic [DW-1:0] ram [NB];
  initial for (int i = 0; i < NB; i++) ram[i] = 8'hEE;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid) rsp0Count++;
      if (rsp1_valid) rsp1Count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: what each cycle must show, derived from the access rules.
  logic [DW-1:0] modelRam [NB];
  int            clrLeft, inWait, pendOwner, lastWinner, win, mAddr;
  logic [DW-1:0] pendData, mData, dueD0, dueD1, expR0, expR1;
  logic          due0, due1, mWe;
  logic          eBusy, eWe, eRe, eRdy0, eRdy1;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eWdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      clrLeft = NB; inWait = 0; lastWinner = 1;
      due0 = 1'b0; due1 = 1'b0; expR0 = '0; expR1 = '0;
    end else begin
      if (due0) expR0 = dueD0;
      if (due1) expR1 = dueD1;
      checkOutput("rsp0_valid", rsp0_valid, due0);
      checkOutput("rsp1_valid", rsp1_valid, due1);
      checkOutput("rsp0_rdata", rsp0_rdata, expR0);
      checkOutput("rsp1_rdata", rsp1_rdata, expR1);
      due0 = 1'b0; due1 = 1'b0;
      eBusy = 0; eWe = 0; eRe = 0; eRdy0 = 0; eRdy1 = 0; eAddr = '0; eWdata = '0;
      if (clrLeft > 0) begin
        eBusy = 1; eWe = 1; eAddr = AW'(NB - clrLeft);
        modelRam[NB - clrLeft] = '0;
        clrLeft--;
      end else if (inWait != 0) begin
        inWait = 0;
        if (pendOwner == 0) begin due0 = 1'b1; dueD0 = pendData; end
        else begin due1 = 1'b1; dueD1 = pendData; end
      end else if (ena && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) win = 1 - lastWinner;
        else win = req0_valid ? 0 : 1;
        lastWinner = win;
        mWe   = (win == 0) ? req0_we : req1_we;
        mAddr = (win == 0) ? int'(req0_addr) : int'(req1_addr);
        mData = (win == 0) ? req0_wdata : req1_wdata;
        eRdy0 = (win == 0); eRdy1 = (win == 1);
        eAddr = AW'(mAddr); eWdata = mData; eWe = mWe; eRe = !mWe;
        if (mWe) modelRam[mAddr] = mData;
        else begin inWait = 1; pendOwner = win; pendData = modelRam[mAddr]; end
      end
      checkOutput("busy", busy, eBusy);
      checkOutput("req0_ready", req0_ready, eRdy0);
      checkOutput("req1_ready", req1_ready, eRdy1);
      checkOutput("mem_we", mem_we, eWe);
      checkOutput("mem_re", mem_re, eRe);
      checkOutput("mem_addr", mem_addr, eAddr);
      checkOutput("mem_wdata", mem_wdata, eWdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic doAccess(input int port, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          output int hs);
    hs = -1;
    tick();
    if (port == 0) applyStimulus(1'b1, we, addr, data, 1'b0, 1'b0, '0, '0);
    else applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, we, addr, data);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (((port == 0) ? req0_ready : req1_ready) === 1'b1) begin
        hs = cycleNo;
        break;
      end
    end
    checkOutput($sformatf("grant_p%0d", port), 32'(hs >= 0), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic waitRsp(input int port, output int cyc, output logic [DW-1:0] data);
    cyc = -1;
    data = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (((port == 0) ? rsp0_valid : rsp1_valid) === 1'b1) begin
        cyc = cycleNo;
        data = (port == 0) ? rsp0_rdata : rsp1_rdata;
        break;
      end
    end
    checkOutput($sformatf("rsp_seen_p%0d", port), 32'(cyc >= 0), 32'd1);
  endtask

  task automatic readCheck(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    int hs, cyc;
    logic [DW-1:0] data;
    doAccess(port, 1'b0, addr, '0, hs);
    waitRsp(port, cyc, data);
    checkOutput($sformatf("read_p%0d_a%0h", port, addr), data, expected);
    checkOutput($sformatf("latency_p%0d_a%0h", port, addr), cyc - hs, 2);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    int hs, n, c0, c1;
    int order[$];
    int k0, k1;

    $display("[TB] reset and zero-fill");
    repeat (2) @(negedge clk);
    checkOutput("reset_rsp0_rdata", rsp0_rdata, 8'h00);
    checkOutput("reset_rsp1_rdata", rsp1_rdata, 8'h00);
    checkOutput("reset_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    countBusy(n);
    checkOutput("clear_cycles", n, 16);
    readCheck(0, 4'h9, 8'h00);

    $display("[TB] write then read from the other port");
    tick();
    c0 = rsp0Count; c1 = rsp1Count;
    doAccess(0, 1'b1, 4'h3, 8'hA5, hs);
    readCheck(1, 4'h3, 8'hA5);
    tick();
    checkOutput("rsp0_quiet", rsp0Count - c0, 0);
    checkOutput("rsp1_one_pulse", rsp1Count - c1, 1);

    $display("[TB] contending writes");
    k0 = 0; k1 = 0;
    for (int i = 0; i < 20 && (k0 < 4 || k1 < 4); i++) begin
      tick();
      applyStimulus(1'(k0 < 4), 1'b1, AW'(k0), DW'(8'h10 + k0), 1'(k1 < 4), 1'b1, AW'(8 + k1), DW'(8'h20 + k1));
      @(negedge clk);
      if (req0_ready) begin order.push_back(0); k0++; end
      if (req1_ready) begin order.push_back(1); k1++; end
    end
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("rr_count", order.size(), 8);
    foreach (order[i]) checkOutput($sformatf("rr_grant%0d", i), order[i], i % 2);
    for (int k = 0; k < 4; k++) begin
      readCheck(0, AW'(k), DW'(8'h10 + k));
      readCheck(1, AW'(8 + k), DW'(8'h20 + k));
    end

    $display("[TB] back-to-back reads");
    doAccess(0, 1'b1, 4'h5, 8'h55, hs);
    doAccess(1, 1'b1, 4'h6, 8'h66, hs);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h5, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("b2b_c0_ready0", req0_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'h6, '0);
    @(negedge clk);
    checkOutput("b2b_c1_ready1", req1_ready, 1'b0);
    @(negedge clk);
    checkOutput("b2b_c2_ready1", req1_ready, 1'b1);
    checkOutput("b2b_c2_rsp0_valid", rsp0_valid, 1'b1);
    checkOutput("b2b_c2_rsp0_rdata", rsp0_rdata, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("b2b_c3_rsp1_valid", rsp1_valid, 1'b0);
    @(negedge clk);
    checkOutput("b2b_c4_rsp1_valid", rsp1_valid, 1'b1);
    checkOutput("b2b_c4_rsp1_rdata", rsp1_rdata, 8'h66);

    $display("[TB] reset during read wait");
    tick();
    applyStimulus(1'b1, 1'b0, 4'h3, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rstwait_ready0", req0_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    ena = 1'b0;
    c0 = rsp0Count; c1 = rsp1Count;
    @(negedge clk);
    checkOutput("rstwait_rsp0_rdata", rsp0_rdata, 8'h00);
    checkOutput("rstwait_rsp1_rdata", rsp1_rdata, 8'h00);
    tick();
    rst_n = 1'b1;
    countBusy(n);
    checkOutput("reclear_cycles", n, 16);
    tick();
    ena = 1'b1;
    checkOutput("rstwait_no_rsp0", rsp0Count - c0, 0);
    checkOutput("rstwait_no_rsp1", rsp1Count - c1, 0);
    readCheck(0, 4'h3, 8'h00);
    readCheck(1, 4'h5, 8'h00);

    $display("[TB] enable gating");
    tick();
    ena = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'h7, 8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ena_block%0d", i), req1_ready, 1'b0);
      tick();
    end
    ena = 1'b1;
    @(negedge clk);
    checkOutput("ena_grant", req1_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h7, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("ena_rd_ready0", req0_ready, 1'b1);
    tick();
    ena = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ena_off_rsp0_valid", rsp0_valid, 1'b1);
    checkOutput("ena_off_rsp0_rdata", rsp0_rdata, 8'h77);
    tick();
    ena = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_mem_arbiter.md
Name: dff_mem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 16x8 DFF RAM macro (addr/wdata/we/re in, registered rdata out, 1-cycle read latency). Zero-fills the RAM after reset. Grants one access per cycle, tracks the in-flight read, and routes read data back to the requester that issued it. Sits between the two internal bus clients and the RAM instance.

Parameters:
ADDR_W, 4, RAM address width; RAM_BYTES must equal 2**ADDR_W.
DATA_W, 8, data width.
RAM_BYTES, 16, RAM depth; also the CLEAR sweep length.
CLEAR_ON_RESET, 1, 1 = zero-fill RAM after reset; 0 = go straight to IDLE.

Ports:
clk  input  1  system clock; all state on posedge.
rst_n  input  1  reset; asynchronous assert, active-low.
ena  input  1  design enable; low blocks new grants.
req0_valid  input  1  requester 0 has an access pending.
req0_we  input  1  1 = write, 0 = read.
req0_addr  input  ADDR_W  access address.
req0_wdata  input  DATA_W  write data.
req0_ready  output  1  grant; access transfers when valid & ready.
rsp0_valid  output  1  one-cycle pulse; rsp0_rdata valid.
rsp0_rdata  output  DATA_W  read data for requester 0.
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata  same as port 0, for requester 1.
mem_addr  output  ADDR_W  RAM address.
mem_wdata  output  DATA_W  RAM write data.
mem_we  output  1  RAM write strobe.
mem_re  output  1  RAM read strobe.
mem_rdata  input  DATA_W  RAM read data; valid the cycle after mem_re.
busy  output  1  high during CLEAR.

Behaviour:
- Reset (async, rst_n low): state = CLEAR if CLEAR_ON_RESET, else IDLE. clr_cnt = 0. last_grant = 1, so requester 0 wins first contention. rsp*_valid = 0, rsp*_rdata = 0. An in-flight read is discarded.
- Combinational outputs: req*_ready and mem_* are decoded from state and inputs. With no access they are 0: mem_addr = 0, mem_wdata = 0, mem_we = 0, mem_re = 0.
- CLEAR:
  - Each cycle: mem_we = 1, mem_addr = clr_cnt, mem_wdata = 0. clr_cnt increments.
  - After the write at clr_cnt = RAM_BYTES-1, go to IDLE. CLEAR lasts exactly RAM_BYTES cycles.
  - busy = 1; both readys = 0. ena is ignored in CLEAR.
- IDLE, ena = 1:
  - Exactly one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - In the grant cycle, readys are combinational: granted ready = 1, other = 0. Neither valid: both readys = 0.
  - mem_addr / mem_wdata are taken from the granted requester in the same cycle. last_grant updates at the clock edge.
- Granted write: mem_we = 1 in the grant cycle, RAM writes at that edge. Stay IDLE; no response. Back-to-back writes: 1 per cycle.
- Granted read: mem_re = 1 in the grant cycle. Record the owner; go to RD_WAIT.
- RD_WAIT:
  - Both readys = 0; mem_we = mem_re = 0.
  - At the edge ending this cycle: rspN_rdata <= mem_rdata for the owner N, rspN_valid <= 1, state -> IDLE.
- Response timing: rspN_valid is high for exactly one cycle, 2 cycles after the read's handshake cycle (handshake cycle C0, rsp valid in C2). A new grant may occur in C2.
  - rsp*_rdata holds its value until the next read for that port.
  - No response backpressure.
- Read throughput: one read per 2 cycles.
- ena = 0:
  - IDLE: no grants, readys = 0, requests wait.
  - RD_WAIT: the in-flight read still completes and its response is still delivered.
- Simultaneous write on one port and read on the other: only one is granted per round-robin; the loser's ready stays 0 and its request must remain asserted.
- Write then read of the same address in consecutive grants returns the new data (the RAM is written before the read edge).
- Address width: addresses are used as-is. RAM_BYTES = 2**ADDR_W, so there are no out-of-range addresses.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1: busy high exactly 16 cycles, mem_we high with mem_addr 0..15 and mem_wdata 0. Then req0 read addr 0x9 -> rsp0_valid 2 cycles after the handshake, rsp0_rdata = 0x00.
- req0 write 0x3 = 0xA5, then req1 read 0x3 -> rsp1_valid one pulse with 0xA5; rsp0_valid stays 0.
- Both requesters hold valid writes (req0 addr k, data 0x10+k; req1 addr 8+k, data 0x20+k) for 8 cycles -> grants alternate 0,1,0,1..., starting with 0. Read-back confirms all 8 values.
- req0 read 0x5 immediately followed by req1 read 0x6 (data 0x55 / 0x66) -> req1_ready = 0 in RD_WAIT. rsp0 = 0x55 in C2, req1 granted in C2, rsp1 = 0x66 in C4.
- rst_n pulsed low during RD_WAIT -> no rsp pulse, rsp*_rdata = 0, CLEAR restarts, RAM reads back 0x00.
- ena dropped while req1 valid -> req1_ready = 0 until ena returns; grant in the first cycle ena = 1. A read already in RD_WAIT when ena drops still produces its rsp pulse.
